writeback_arb: RTL and testbench

// - Parametrised MIPS writeback stage: registers the M->W result and arbitrates the single register-file write port between the main pipe and a late-result channel (multiply/divide unit), buffering late results in a small FIFO.
// - Also produces next-fetch PC (jump / branch / PC+4 mux) for the F stage.

---
 rtl/writeback_arb_if.sv | 14 +
 rtl/writeback_arb.sv | 156 +++++++++++++++
 tb/tb_writeback_arb.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arb_if.sv
// Late-result channel between the multiply/divide unit and the writeback arbiter.
// The producer drives valid/reg/data; the arbiter answers with ready.
interface writeback_arb_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              md_valid;
   logic              md_ready;
   logic [REG_AW-1:0] md_reg;
   logic [DATA_W-1:0] md_data;

   modport master (output md_valid, output md_reg, output md_data, input md_ready);
   modport slave  (input md_valid, input md_reg, input md_data, output md_ready);
endinterface

// File: rtl/writeback_arb.sv
// MIPS writeback stage: W registers, write-port arbitration with a late-result FIFO, next-PC mux.
// Optional: define WB_ZERO_SUPPRESS_EN to drop register-file writes aimed at register 0.
module writeback_arb #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int NSRC       = 3,
   parameter int LINK_REG   = 31,
   parameter int FIFO_DEPTH = 4,
   localparam int SEL_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stallW,
   input  logic                   flushW,
   input  logic                   RegWriteM,
   input  logic                   jumpM,
   input  logic [SEL_W-1:0]       MemtoRegM,
   input  logic [REG_AW-1:0]      WriteRegM,
   input  logic [NSRC*DATA_W-1:0] SrcDataM,
   writeback_arb_if.slave         md,
   input  logic                   PCSrcD,
   input  logic                   jumpD,
   input  logic [DATA_W-5:0]      jumpDstD,
   input  logic [DATA_W-1:0]      PCPlus4F,
   input  logic [DATA_W-1:0]      PCBranchD,
   output logic                   RegWriteW,
   output logic [REG_AW-1:0]      WriteRegW,
   output logic [DATA_W-1:0]      ResultW,
   output logic                   md_pending,
   output logic [DATA_W-1:0]      PC
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   logic [REG_AW+DATA_W-1:0] fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wrPtr;
   logic [PTR_W-1:0]         rdPtr;
   logic [CNT_W-1:0]         count;

   logic                     mainWr;
   logic [REG_AW-1:0]        mainDst;
   logic [DATA_W-1:0]        mainVal;
   logic                     mdReady;
   logic                     mdAcc;
   logic                     fifoNonEmpty;
   logic [REG_AW-1:0]        headReg;
   logic [DATA_W-1:0]        headData;

   logic                     push;
   logic                     pop;
   logic                     slotUsed;
   logic [REG_AW-1:0]        slotDst;
   logic [DATA_W-1:0]        slotVal;
   logic                     zeroKill;

   // Next-fetch PC
   assign PC = jumpD  ? {PCPlus4F[DATA_W-1 -: 4], jumpDstD} :
               PCSrcD ? PCBranchD : PCPlus4F;

   assign mainWr  = RegWriteM & ~stallW & ~flushW;
   assign mainDst = jumpM ? REG_AW'(LINK_REG) : WriteRegM;

   // Out-of-range selects read as zero rather than aliasing onto a real source
   always_comb begin
      mainVal = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (int'(MemtoRegM) == i) begin
            mainVal = SrcDataM[i*DATA_W +: DATA_W];
         end
      end
   end

   // Ready is a function of occupancy only, so the producer never sees a combinational path from pop
   assign mdReady      = (count != FULL_CNT);
   assign mdAcc        = md.md_valid & mdReady;
   assign fifoNonEmpty = (count != '0);
   assign md.md_ready  = mdReady;
   assign md_pending   = fifoNonEmpty;

   assign {headReg, headData} = fifoMem[rdPtr];

   always_comb begin
      push     = 1'b0;
      pop      = 1'b0;
      slotUsed = 1'b0;
      slotDst  = WriteRegW;
      slotVal  = ResultW;
      if (mainWr) begin
         slotUsed = 1'b1;
         slotDst  = mainDst;
         slotVal  = mainVal;
         push     = mdAcc;
      end else if (fifoNonEmpty) begin
         slotUsed = 1'b1;
         slotDst  = headReg;
         slotVal  = headData;
         pop      = 1'b1;
         push     = mdAcc;
      end else if (mdAcc) begin
         slotUsed = 1'b1;
         slotDst  = md.md_reg;
         slotVal  = md.md_data;
      end
   end

`ifdef WB_ZERO_SUPPRESS_EN
   assign zeroKill = (slotDst == '0);
`else
   assign zeroKill = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW <= 1'b0;
         WriteRegW <= '0;
         ResultW   <= '0;
      end else begin
         RegWriteW <= slotUsed & ~zeroKill;
         if (slotUsed) begin
            WriteRegW <= slotDst;
            ResultW   <= slotVal;
         end
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count alone
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= {md.md_reg, md.md_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_arb.sv
// Self-checking bench for writeback_arb: queue-based reference model plus directed scenarios.
module tb_writeback_arb;

   logic        clk;
   logic        rst;
   logic        stallW, flushW, RegWriteM, jumpM;
   logic [1:0]  MemtoRegM;
   logic [4:0]  WriteRegM;
   logic [31:0] src [3];
   logic [95:0] SrcDataM;
   logic        PCSrcD, jumpD;
   logic [27:0] jumpDstD;
   logic [31:0] PCPlus4F, PCBranchD;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        md_pending;
   logic [31:0] PC;

   int checks = 0;
   int errors = 0;

   writeback_arb_if #(.DATA_W(32), .REG_AW(5)) mdIf ();

   writeback_arb #(.DATA_W(32), .REG_AW(5), .NSRC(3), .LINK_REG(31), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .RegWriteM(RegWriteM),
      .jumpM(jumpM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .SrcDataM(SrcDataM),
      .md(mdIf), .PCSrcD(PCSrcD), .jumpD(jumpD), .jumpDstD(jumpDstD), .PCPlus4F(PCPlus4F),
      .PCBranchD(PCBranchD), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .md_pending(md_pending), .PC(PC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb SrcDataM = {src[2], src[1], src[0]};

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: late results held in a plain queue, W outputs derived from the priority rules
   typedef struct { logic [4:0] r; logic [31:0] d; } lateT;
   lateT        mQ[$];
   logic        mWe  = 1'b0;
   logic [4:0]  mDst = '0;
   logic [31:0] mVal = '0;

   always @(posedge clk or negedge rst) begin : model
      bit         acc, mainWr, used;
      logic [4:0] d;
      logic [31:0] v;
      lateT       e, ne;
      if (!rst) begin
         mQ.delete();
         mWe  = 1'b0;
         mDst = '0;
         mVal = '0;
      end else begin
         acc    = mdIf.md_valid && (mQ.size() < 4);
         mainWr = RegWriteM && !stallW && !flushW;
         ne.r   = mdIf.md_reg;
         ne.d   = mdIf.md_data;
         used   = 1'b1;
         d      = '0;
         v      = '0;
         if (mainWr) begin
            d = jumpM ? 5'd31 : WriteRegM;
            v = (MemtoRegM < 2'd3) ? src[MemtoRegM] : 32'd0;
            if (acc) mQ.push_back(ne);
         end else if (mQ.size() > 0) begin
            e = mQ.pop_front();
            d = e.r;
            v = e.d;
            if (acc) mQ.push_back(ne);
         end else if (acc) begin
            d = ne.r;
            v = ne.d;
         end else begin
            used = 1'b0;
         end
         if (used) begin
            mDst = d;
            mVal = v;
            mWe  = 1'b1;
`ifdef WB_ZERO_SUPPRESS_EN
            if (d == 5'd0) mWe = 1'b0;
`endif
         end else begin
            mWe = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("cmp_RegWriteW", 64'(RegWriteW), 64'(mWe));
         check("cmp_WriteRegW", 64'(WriteRegW), 64'(mDst));
         check("cmp_ResultW", 64'(ResultW), 64'(mVal));
         check("cmp_md_ready", 64'(mdIf.md_ready), 64'(mQ.size() < 4));
         check("cmp_md_pending", 64'(md_pending), 64'(mQ.size() > 0));
         check("cmp_PC", 64'(PC), 64'(jumpD ? {PCPlus4F[31:28], jumpDstD} : (PCSrcD ? PCBranchD : PCPlus4F)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      stallW = 0; flushW = 0; RegWriteM = 0; jumpM = 0; MemtoRegM = 0; WriteRegM = 0;
      mdIf.md_valid = 0; mdIf.md_reg = 0; mdIf.md_data = 0;
   endtask

   task automatic mainWrite(input logic [4:0] r, input logic [1:0] sel);
      RegWriteM = 1; WriteRegM = r; MemtoRegM = sel; jumpM = 0; stallW = 0; flushW = 0;
   endtask

   task automatic late(input logic v, input logic [4:0] r, input logic [31:0] d);
      mdIf.md_valid = v; mdIf.md_reg = r; mdIf.md_data = d;
   endtask

   initial begin
      rst = 0;
      idle();
      src[0] = 32'h0; src[1] = 32'h0; src[2] = 32'h0;
      PCSrcD = 0; jumpD = 0; jumpDstD = '0; PCPlus4F = 32'h0000_0004; PCBranchD = 32'h0;
      repeat (2) tick();
      check("reset_RegWriteW", 64'(RegWriteW), 64'd0);
      check("reset_WriteRegW", 64'(WriteRegW), 64'd0);
      check("reset_ResultW", 64'(ResultW), 64'd0);
      check("reset_md_pending", 64'(md_pending), 64'd0);
      check("reset_md_ready", 64'(mdIf.md_ready), 64'd1);
      rst = 1;
      tick();

      // memory-source write
      src[2] = 32'hDEAD_BEEF; src[1] = 32'h1111_1111; src[0] = 32'h2222_2222;
      mainWrite(5'd8, 2'd2);
      tick();
      check("mem_RegWriteW", 64'(RegWriteW), 64'd1);
      check("mem_WriteRegW", 64'(WriteRegW), 64'd8);
      check("mem_ResultW", 64'(ResultW), 64'hDEAD_BEEF);

      // jump-and-link
      src[0] = 32'h0040_0008;
      mainWrite(5'd3, 2'd0); jumpM = 1;
      tick();
      check("jal_WriteRegW", 64'(WriteRegW), 64'd31);
      check("jal_ResultW", 64'(ResultW), 64'h0040_0008);

      // bypass with idle main pipe
      idle(); late(1, 5'd5, 32'd7);
      tick();
      check("byp_RegWriteW", 64'(RegWriteW), 64'd1);
      check("byp_WriteRegW", 64'(WriteRegW), 64'd5);
      check("byp_ResultW", 64'(ResultW), 64'd7);
      check("byp_md_pending", 64'(md_pending), 64'd0);
      idle();
      tick();
      check("hold_RegWriteW", 64'(RegWriteW), 64'd0);
      check("hold_WriteRegW", 64'(WriteRegW), 64'd5);
      check("hold_ResultW", 64'(ResultW), 64'd7);

      // out-of-range source select
      mainWrite(5'd4, 2'd3);
      tick();
      check("oor_ResultW", 64'(ResultW), 64'd0);

      // burst: main busy for 5 cycles while the late channel offers 5 results
      for (int i = 0; i < 5; i++) begin
         mainWrite(5'd20, 2'd1);
         late(1, 5'(10 + i), 32'(100 + i));
         #1;
         check("burst_md_ready", 64'(mdIf.md_ready), (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      check("burst_md_pending", 64'(md_pending), 64'd1);
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_RegWriteW", 64'(RegWriteW), 64'd1);
         check("drain_WriteRegW", 64'(WriteRegW), 64'(10 + i));
         check("drain_ResultW", 64'(ResultW), 64'(100 + i));
      end
      tick();
      check("drained_RegWriteW", 64'(RegWriteW), 64'd0);
      check("drained_md_pending", 64'(md_pending), 64'd0);

      // stall lets the buffered late result through
      mainWrite(5'd21, 2'd1); late(1, 5'd9, 32'h99);
      tick();
      idle(); mainWrite(5'd12, 2'd1); stallW = 1;
      tick();
      check("stall_RegWriteW", 64'(RegWriteW), 64'd1);
      check("stall_WriteRegW", 64'(WriteRegW), 64'd9);
      check("stall_ResultW", 64'(ResultW), 64'h99);

      // flush with empty FIFO
      idle(); mainWrite(5'd12, 2'd1); flushW = 1;
      tick();
      check("flush_RegWriteW", 64'(RegWriteW), 64'd0);

      // simultaneous push and pop keeps occupancy
      idle(); mainWrite(5'd13, 2'd1); late(1, 5'd14, 32'h140);
      tick();
      idle(); late(1, 5'd15, 32'h150);
      tick();
      check("pp_WriteRegW", 64'(WriteRegW), 64'd14);
      check("pp_md_pending", 64'(md_pending), 64'd1);
      idle();
      tick();
      check("pp2_WriteRegW", 64'(WriteRegW), 64'd15);

      // next-PC mux
      jumpD = 1; PCSrcD = 0; PCPlus4F = 32'h1000_0004; jumpDstD = 28'h000_0100; PCBranchD = 32'h0000_1234;
      #1 check("pc_jump", 64'(PC), 64'h1000_0100);
      jumpD = 0; PCSrcD = 1;
      #1 check("pc_branch", 64'(PC), 64'h0000_1234);
      PCSrcD = 0;
      #1 check("pc_fall", 64'(PC), 64'h1000_0004);
      tick();

      // register 0 destination
      idle(); mainWrite(5'd0, 2'd1);
      tick();
`ifdef WB_ZERO_SUPPRESS_EN
      check("zero_RegWriteW", 64'(RegWriteW), 64'd0);
`else
      check("zero_RegWriteW", 64'(RegWriteW), 64'd1);
`endif

      // mixed traffic against the model
      for (int i = 0; i < 60; i++) begin
         RegWriteM = ($urandom_range(0, 2) != 0);
         stallW    = ($urandom_range(0, 4) == 0);
         flushW    = ($urandom_range(0, 6) == 0);
         jumpM     = ($urandom_range(0, 7) == 0);
         MemtoRegM = 2'($urandom_range(0, 3));
         WriteRegM = 5'($urandom_range(0, 31));
         src[0] = $urandom; src[1] = $urandom; src[2] = $urandom;
         late($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
         jumpD = ($urandom_range(0, 3) == 0); PCSrcD = ($urandom_range(0, 1) == 1);
         PCPlus4F = $urandom; PCBranchD = $urandom; jumpDstD = 28'($urandom);
         tick();
      end

      // asynchronous reset with three buffered entries
      idle();
      repeat (4) tick();
      for (int i = 0; i < 3; i++) begin
         mainWrite(5'd22, 2'd1); late(1, 5'(1 + i), 32'(i + 1));
         tick();
      end
      check("pre_rst_md_pending", 64'(md_pending), 64'd1);
      rst = 0;
      #1;
      check("arst_RegWriteW", 64'(RegWriteW), 64'd0);
      check("arst_WriteRegW", 64'(WriteRegW), 64'd0);
      check("arst_ResultW", 64'(ResultW), 64'd0);
      check("arst_md_pending", 64'(md_pending), 64'd0);
      check("arst_md_ready", 64'(mdIf.md_ready), 64'd1);
      idle();
      #3 rst = 1;
      repeat (2) tick();
      check("post_rst_RegWriteW", 64'(RegWriteW), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
